feature_frame_buffer: RTL and testbench

FEATURE_FRAME_BUFFER -- requirements
Module: feature_frame_buffer

---
 rtl/feature_frame_buffer_pkg.sv | 32 +++
 rtl/feature_frame_buffer_fb_dpram.sv | 32 +++
 rtl/feature_frame_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_feature_frame_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_frame_buffer_pkg.sv
// Shared definitions for the feature frame buffer.
//   IMG_W / IMG_H : default frame geometry (pixels per row / rows per frame)
//   ZERO_POINT    : offset subtracted from an unsigned pixel to form the int8 feature
//   PIX_W         : pixel width
//   COORD_W       : width of the x/y coordinate inputs
//   frame_aw()    : address width of one frame bank
//   wr_state_t / rd_state_t : write and read FSM encodings
package feature_frame_buffer_pkg;

  localparam int IMG_W      = 64;
  localparam int IMG_H      = 64;
  localparam int ZERO_POINT = 128;
  localparam int PIX_W      = 8;
  localparam int COORD_W    = 6;

  function automatic int frame_aw(input int w, input int h);
    return $clog2(w * h);
  endfunction

  typedef enum logic [1:0] {
    WR_SYNC = 2'd0,
    WR_FILL = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/feature_frame_buffer_fb_dpram.sv
// fb_dpram: simple dual-port frame storage, one write port and one read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is registered and holds while re is low
//   rdata        : read data, valid one cycle after the request
module fb_dpram
  import feature_frame_buffer_pkg::*;
#(
  parameter int DEPTH = 2 * IMG_W * IMG_H,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/feature_frame_buffer.sv
// Ping-pong frame buffer between the resizer and the ML core.
// Pixels arrive as (pixel, x, y) strobes and are stored by address; complete
// frames are streamed out in raster order as signed int8 features.
//   clk, resetn      : clock, asynchronous active-low reset
//   pixel_in/x_in/y_in/valid_in : input pixel strobe, no backpressure
//   out_data/out_valid/out_ready/out_last : feature stream, valid/ready handshake
//   frame_dropped    : one-cycle pulse per complete input frame discarded
//
// Write FSM
//   state   | meaning
//   WR_SYNC | waiting for a (0,0) strobe to start a frame in the write bank
//   WR_FILL | writing strobes by address until (IMG_W-1, IMG_H-1)
//   WR_WAIT | both banks full; input discarded until the reader frees a bank
// Read FSM
//   state     | meaning
//   RD_IDLE   | read bank not full, nothing in flight
//   RD_PRIME  | element 0 of the bank is in the RAM output register
//   RD_STREAM | elements flowing through the RAM register and output register
module feature_frame_buffer #(
  parameter int IMG_W = feature_frame_buffer_pkg::IMG_W,
  parameter int IMG_H = feature_frame_buffer_pkg::IMG_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] pixel_in,
  input  logic [5:0] x_in,
  input  logic [5:0] y_in,
  input  logic       valid_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_dropped
);

  import feature_frame_buffer_pkg::*;

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int AW        = frame_aw(IMG_W, IMG_H);
  localparam logic [AW:0]   BANK1_BASE = (AW+1)'(FRAME_PIX);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(FRAME_PIX - 1);

  // bank 1 sits directly above bank 0 in the shared RAM
  function automatic logic [AW:0] bank_addr(input logic bank, input logic [AW-1:0] addr);
    return bank ? (BANK1_BASE + {1'b0, addr}) : {1'b0, addr};
  endfunction

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [1:0]    bank_full, bank_full_nxt;
  logic          wr_bank;
  logic          rd_bank;

  logic          pix_first;
  logic          pix_last;
  logic [AW-1:0] pix_addr;

  logic          wr_en;
  logic          wr_complete;
  logic          wr_toggle;
  logic          drop_nxt;
  logic          other_empty;

  logic          advance;
  logic          last_hs;
  logic          rd_issue;
  logic          rd_start;
  logic          rd_issue_bank;
  logic [AW-1:0] rd_issue_addr;
  logic [AW-1:0] raddr;
  logic          rd_more;
  logic          q_vld;
  logic          q_last;
  logic [7:0]    q_rdata;

  assign pix_first = (x_in == '0) && (y_in == '0);
  assign pix_last  = (x_in == COORD_W'(IMG_W - 1)) && (y_in == COORD_W'(IMG_H - 1));
  assign pix_addr  = AW'(int'(y_in) * IMG_W + int'(x_in));

  // Output register and RAM output register stall together.
  assign advance = !out_valid || out_ready;
  assign last_hs = out_valid && out_last && out_ready;

  // A bank freed by the reader this cycle counts as empty for the writer.
  assign other_empty = !bank_full[~wr_bank] || (last_hs && (rd_bank != wr_bank));

  always_comb begin
    wr_state_nxt = wr_state;
    wr_en        = 1'b0;
    wr_toggle    = 1'b0;
    drop_nxt     = 1'b0;
    wr_complete  = 1'b0;
    case (wr_state)
      WR_SYNC: begin
        if (valid_in && pix_first) begin
          wr_en        = 1'b1;
          wr_state_nxt = WR_FILL;
        end
      end
      WR_FILL: begin
        wr_en = valid_in;
      end
      WR_WAIT: begin
        drop_nxt = valid_in && pix_last;
        if (other_empty) begin
          wr_toggle    = 1'b1;
          wr_state_nxt = WR_SYNC;
        end
      end
      default: wr_state_nxt = WR_SYNC;
    endcase
    wr_complete = wr_en && pix_last;
    if (wr_complete) begin
      if (other_empty) begin
        wr_toggle    = 1'b1;
        wr_state_nxt = WR_SYNC;
      end else begin
        wr_state_nxt = WR_WAIT;
      end
    end
  end

  always_comb begin
    bank_full_nxt = bank_full;
    if (last_hs) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
    if (wr_complete) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
  end

  always_comb begin
    rd_state_nxt  = rd_state;
    rd_issue      = 1'b0;
    rd_start      = 1'b0;
    rd_issue_bank = rd_bank;
    case (rd_state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_issue     = 1'b1;
          rd_start     = 1'b1;
          rd_state_nxt = RD_PRIME;
        end
      end
      RD_PRIME: begin
        rd_issue     = rd_more;
        rd_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        if (last_hs) begin
          // Prefetch element 0 of the other bank so a waiting frame follows
          // with a single idle cycle.
          if (bank_full[~rd_bank]) begin
            rd_issue      = 1'b1;
            rd_start      = 1'b1;
            rd_issue_bank = ~rd_bank;
            rd_state_nxt  = RD_PRIME;
          end else begin
            rd_state_nxt = RD_IDLE;
          end
        end else begin
          rd_issue = advance && rd_more;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  assign rd_issue_addr = rd_start ? '0 : raddr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state      <= WR_SYNC;
      wr_bank       <= 1'b0;
      bank_full     <= 2'b00;
      frame_dropped <= 1'b0;
    end else begin
      wr_state      <= wr_state_nxt;
      bank_full     <= bank_full_nxt;
      frame_dropped <= drop_nxt;
      if (wr_toggle) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      raddr     <= '0;
      rd_more   <= 1'b0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      if (last_hs) begin
        rd_bank <= ~rd_bank;
      end
      if (rd_issue) begin
        if (rd_start) begin
          raddr   <= AW'(1);
          rd_more <= (FRAME_PIX > 1);
        end else if (raddr == LAST_ADDR) begin
          rd_more <= 1'b0;
        end else begin
          raddr <= raddr + AW'(1);
        end
      end
      if (advance) begin
        q_vld     <= rd_issue;
        q_last    <= rd_issue && (rd_issue_addr == LAST_ADDR);
        out_valid <= q_vld;
        out_last  <= q_vld && q_last;
        out_data  <= q_vld ? (q_rdata - PIX_W'(ZERO_POINT)) : '0;
      end
    end
  end

  fb_dpram #(
    .DEPTH (2 * FRAME_PIX),
    .AW    (AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (bank_addr(wr_bank, pix_addr)),
    .wdata (pixel_in),
    .re    (rd_issue),
    .raddr (bank_addr(rd_issue_bank, rd_issue_addr)),
    .rdata (q_rdata)
  );

endmodule

// File: tb/tb_feature_frame_buffer.sv
module tb_feature_frame_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] pixel_in;
  logic [5:0] x_in;
  logic [5:0] y_in;
  logic       valid_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       frame_dropped;

  always #5 clk = ~clk;

  feature_frame_buffer dut (
    .clk           (clk),
    .resetn        (resetn),
    .pixel_in      (pixel_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .valid_in      (valid_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_dropped (frame_dropped)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expected stream: {last, data}
  logic [8:0] exp_q [$];
  logic [8:0] e;
  logic [7:0] cap [0:8191];
  int         hs_cnt, last_cnt, drop_cnt, max_gap, gap_run;
  logic       seen_last;
  logic       stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  int         ready_mode = 0;  // 0 low, 1 high, 2 random

  function automatic logic [7:0] pat(input int p, input int x, input int y);
    case (p)
      0:       return 8'(x + y);
      1:       return 8'(x * 3 + y * 5 + 17);
      2:       return 8'(255 - x - 2 * y);
      3:       return 8'(x ^ (y * 4));
      default: return 8'(x * y + 1);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; last_cnt = 0; drop_cnt = 0; max_gap = 0; gap_run = 0; seen_last = 1'b0;
  endtask

  task automatic expect_frame(input int p);
    logic [7:0] v;
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        v = pat(p, x, y) - 8'd128;
        exp_q.push_back({(x == 63 && y == 63), v});
      end
    end
  endtask

  task automatic drive_pix(input int p, input int x, input int y);
    pixel_in = pat(p, x, y);
    x_in     = 6'(x);
    y_in     = 6'(y);
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int p, input int x0, input int y0);
    for (int y = y0; y < 64; y++) begin
      for (int x = ((y == y0) ? x0 : 0); x < 64; x++) begin
        drive_pix(p, x, y);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: every handshake pops the model queue; stalls must hold.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (stall_prev) begin
        n_cmp++;
        if (!out_valid || out_data !== hold_data || out_last !== hold_last) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b data=0x%0h last=%0b, required valid=1 data=0x%0h last=%0b",
                   out_valid, out_data, out_last, hold_data, hold_last);
        end
      end
      if (frame_dropped) drop_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_output: got data=0x%0h last=%0b, required no output", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (out_data !== e[7:0] || out_last !== e[8]) begin
            n_err++;
            $display("FAIL out_elem[%0d]: got data=0x%0h last=%0b, required data=0x%0h last=%0b",
                     hs_cnt, out_data, out_last, e[7:0], e[8]);
          end
        end
        if (hs_cnt < 8192) cap[hs_cnt] = out_data;
        if (seen_last && gap_run > max_gap) max_gap = gap_run;
        seen_last = out_last;
        gap_run   = 0;
        hs_cnt++;
        if (out_last) last_cnt++;
      end else if (seen_last) begin
        gap_run++;
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_last  = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    resetn = 1'b1; valid_in = 1'b0; pixel_in = '0; x_in = '0; y_in = '0;
    clear_stats();
    #1 resetn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_dropped", frame_dropped, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Back-to-back frames, consumer always ready.
    ready_mode = 1;
    clear_stats();
    expect_frame(0);
    expect_frame(1);
    send_frame(0, 0, 0);
    send_frame(1, 0, 0);
    wait_drain(6000);
    check("b2b_count", hs_cnt, 8192);
    check("b2b_lasts", last_cnt, 2);
    check("b2b_first_0x80", cap[0], 8'h80);
    check("b2b_x1y0_0x81", cap[1], 8'h81);
    check("b2b_x0y1_0x81", cap[64], 8'h81);
    check("b2b_x63y63_0xFE", cap[4095], 8'hFE);
    check("b2b_f2_first_0x91", cap[4096], 8'h91);
    check("b2b_gap_le1", (max_gap <= 1) ? 1 : 0, 1);
    check("b2b_no_drop", drop_cnt, 0);

    // Random backpressure.
    do_reset();
    clear_stats();
    ready_mode = 2;
    expect_frame(4);
    send_frame(4, 0, 0);
    wait_drain(12000);
    ready_mode = 1;
    check("rnd_count", hs_cnt, 4096);
    check("rnd_lasts", last_cnt, 1);

    // Consumer stalled, three frames: third is dropped.
    do_reset();
    clear_stats();
    ready_mode = 0;
    expect_frame(0);
    expect_frame(1);
    send_frame(0, 0, 0);
    send_frame(1, 0, 0);
    send_frame(2, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("stall_no_hs", hs_cnt, 0);
    check("stall_valid_held", out_valid, 1);
    check("stall_drop_pulses", drop_cnt, 1);
    ready_mode = 1;
    wait_drain(10000);
    check("stall_count", hs_cnt, 8192);
    check("stall_lasts", last_cnt, 2);
    check("stall_drop_total", drop_cnt, 1);

    // Input starting mid-frame is ignored; first-output latency.
    do_reset();
    clear_stats();
    ready_mode = 1;
    expect_frame(3);
    send_frame(2, 10, 5);
    send_frame(3, 0, 0);
    check("lat_edge_n", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge_n1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge_n2_valid", out_valid, 1);
    check("lat_edge_n2_data", out_data, 8'h80);
    wait_drain(6000);
    check("mid_count", hs_cnt, 4096);
    check("mid_no_drop", drop_cnt, 0);

    // Reset in the middle of streaming.
    do_reset();
    clear_stats();
    ready_mode = 1;
    expect_frame(1);
    send_frame(1, 0, 0);
    n = 0;
    while (hs_cnt < 2000 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_stream_reached", (hs_cnt >= 2000) ? 1 : 0, 1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_last", out_last, 0);
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    clear_stats();
    expect_frame(4);
    send_frame(4, 0, 0);
    wait_drain(6000);
    check("post_rst_count", hs_cnt, 4096);
    check("post_rst_lasts", last_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
